// File: rtl/aes_inv_cipher_iter.sv
// Iterative AES inverse cipher with one shared round datapath, runtime AES-128/192/256 selection
// and a tag carried with each block through ready/valid input and output stages.
module aes_inv_cipher_iter #(
    parameter int TAG_W  = 8,
    parameter int NR_MAX = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [127:0]     k_sch [0:NR_MAX],
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_mode,
    input  logic [127:0]     in_ct,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [127:0]     out_pt,
    output logic [TAG_W-1:0] out_tag,
    output logic             mode_err
);

    // Handshakes: a transfer occurs on a rising edge where valid && ready are both high;
    // valid never depends on ready, and in_ready depends only on the FSM state.

    typedef enum logic [1:0] {IDLE, ROUND, FINAL} fsm_t;

    localparam logic [3:0] NR_LIM = 4'(NR_MAX);

    fsm_t         fsm_q, fsm_d;
    logic [3:0]   rnd_q;
    logic [127:0] blk_q;
    logic [TAG_W-1:0] tag_q;
    logic [3:0]   nr_sel;
    logic         mode_bad;
    logic [127:0] isb, ark, imc;
    logic         accept, out_free, load_out;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0 as the S-box needs.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] p, r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sub_byte(input logic [7:0] y);
        logic [7:0] t;
        t = {y[6:0], y[7]} ^ {y[4:0], y[7:5]} ^ {y[1:0], y[7:2]} ^ 8'h05;
        return gf_inv(t);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    always_comb begin
        nr_sel   = 4'd10;
        mode_bad = 1'b0;
        case (in_mode)
            2'b00:   nr_sel = 4'd10;
            2'b01:   nr_sel = 4'd12;
            2'b10:   nr_sel = 4'd14;
            default: mode_bad = 1'b1;
        endcase
        if (nr_sel > NR_LIM) begin
            nr_sel   = 4'd10;
            mode_bad = 1'b1;
        end
    end

    // Byte i = row (i%4), column (i/4); InvShiftRows rotates row r right by r columns.
    always_comb begin
        isb = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                isb[127-8*(4*c+r) -: 8] = inv_sub_byte(blk_q[127-8*(4*((c-r+4)%4)+r) -: 8]);
            end
        end
    end

    // rnd_q is 0 in FINAL, so the same key mux supplies k_sch[0] for the last round.
    assign ark = isb ^ k_sch[rnd_q];

    always_comb begin
        imc = '0;
        for (int c = 0; c < 4; c++) begin
            imc[127-32*c -: 32] = inv_mix_col(ark[127-32*c -: 32]);
        end
    end

    assign in_ready = (fsm_q == IDLE);
    assign accept   = in_valid && in_ready;
    assign out_free = !out_valid || out_ready;
    assign load_out = (fsm_q == FINAL) && out_free;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fsm_q <= IDLE;
        else        fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid) fsm_d = ROUND;
            ROUND:   if (rnd_q == 4'd1) fsm_d = FINAL;
            FINAL:   if (out_free) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd_q     <= 4'd0;
            blk_q     <= '0;
            tag_q     <= '0;
            out_valid <= 1'b0;
            out_pt    <= '0;
            out_tag   <= '0;
            mode_err  <= 1'b0;
        end else begin
            if (accept) begin
                blk_q <= in_ct ^ k_sch[nr_sel];
                rnd_q <= nr_sel - 4'd1;
                tag_q <= in_tag;
                if (mode_bad) mode_err <= 1'b1;
            end else if (fsm_q == ROUND) begin
                blk_q <= imc;
                rnd_q <= rnd_q - 4'd1;
            end
            // A new result may replace one being handed off in the same cycle.
            if (load_out) begin
                out_valid <= 1'b1;
                out_pt    <= ark;
                out_tag   <= tag_q;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
